dmem_arbiter: RTL and testbench

Arbitrates the single data memory between two requesters: the MIPS core data port (port 0) and a DMA/loader engine (port 1). The CPU normally has priority. The DMA can hold the memory for a bounded burst, and a starvation counter guarantees it progress. Sits in top between mips/dmem; drives dmem we/a/wd and returns rd to both requesters.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and helpers for the data-memory arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BURST)
//   owner_t     : which requester drives the memory port this cycle
//   ctr_width() : bits needed to hold a counter value in 0..max_val
package dmem_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    function automatic int ctr_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the CPU data port (port 0)
// and a DMA/loader engine (port 1). The CPU normally wins; the DMA may hold
// the memory for a burst of up to MAX_BURST beats, and a starvation counter
// forces a DMA win after STARVE_LIMIT consecutive denied cycles.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      CPU access request (combinational grant)
//   cpu_rdata, cpu_stall       CPU load data (= mem_rdata), CPU denied
//   dma_req/we/addr/wdata/last DMA beat request, held until dma_gnt
//   dma_gnt                    DMA beat accepted this cycle
//   dma_rdata, dma_rvalid      registered DMA read data, valid one cycle
//   mem_we/addr/wdata          memory write enable / address / write data
//   mem_rdata                  memory combinational read data
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_BURST    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic          dma_last,
    output logic          dma_gnt,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_rvalid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int BW = ctr_width(MAX_BURST);
    localparam int SW = ctr_width(STARVE_LIMIT);

    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    // Beat count at which the next granted beat closes the burst.
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    arb_state_t    state, state_nxt;
    logic [BW-1:0] beat_cnt, beat_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    owner_t        owner;
    logic          cpu_gnt;
    logic          dma_rd_beat;

    // ---- state / counter registers and DMA read capture ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            starve_cnt <= '0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            state      <= state_nxt;
            beat_cnt   <= beat_nxt;
            starve_cnt <= starve_nxt;
            dma_rvalid <= dma_rd_beat;
            if (dma_rd_beat) begin
                dma_rdata <= mem_rdata;
            end
        end
    end

    // ---- grant decision and next state ----
    always_comb begin
        owner      = OWN_NONE;
        state_nxt  = state;
        beat_nxt   = beat_cnt;
        starve_nxt = '0;

        if (!reset) begin
            case (state)
                IDLE: begin
                    if (dma_req && (starve_cnt == STARVE_MAX)) begin
                        owner = OWN_DMA;
                    end else if (cpu_req) begin
                        owner = OWN_CPU;
                    end else if (dma_req) begin
                        owner = OWN_DMA;
                    end
                    // A single-beat burst never leaves IDLE.
                    if ((owner == OWN_DMA) && !dma_last && (MAX_BURST > 1)) begin
                        state_nxt = BURST;
                        beat_nxt  = BW'(1);
                    end
                end
                BURST: begin
                    if (dma_req) begin
                        owner = OWN_DMA;
                        if (dma_last || (beat_cnt == BURST_LAST)) begin
                            state_nxt = IDLE;
                            beat_nxt  = '0;
                        end else begin
                            beat_nxt = beat_cnt + BW'(1);
                        end
                    end else begin
                        // DMA went quiet: abandon the burst, let the CPU in.
                        owner     = cpu_req ? OWN_CPU : OWN_NONE;
                        state_nxt = IDLE;
                        beat_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    beat_nxt  = '0;
                end
            endcase

            if (dma_req && (owner != OWN_DMA)) begin
                starve_nxt = (starve_cnt == STARVE_MAX) ? STARVE_MAX
                                                        : starve_cnt + SW'(1);
            end
        end
    end

    // ---- memory port mux and requester outputs ----
    always_comb begin
        cpu_gnt     = (owner == OWN_CPU);
        dma_gnt     = (owner == OWN_DMA);
        cpu_stall   = cpu_req && !cpu_gnt && !reset;
        dma_rd_beat = dma_gnt && !dma_we;

        mem_we    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        case (owner)
            OWN_CPU: begin
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            OWN_DMA: begin
                mem_we    = dma_we;
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
            end
            default: begin
                // No owner: keep the CPU address on the bus so cpu_rdata
                // still reflects the word the core is pointing at.
                mem_we    = 1'b0;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
        endcase
    end

    assign cpu_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a cycle model of the
// arbitration rules and a small word memory behind the mem_* port.
module tb_dmem_arbiter;

    localparam int AW           = 32;
    localparam int DW           = 32;
    localparam int MAX_BURST    = 4;
    localparam int STARVE_LIMIT = 8;

    logic          clk;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          dma_req, dma_we, dma_last;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          dma_gnt, dma_rvalid;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    dmem_arbiter #(
        .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_last(dma_last), .dma_gnt(dma_gnt),
        .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 64-word memory, word i preset to 0x1000+i while mem_init is high.
    logic [DW-1:0] mem [0:63];
    logic          mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000 + 32'(i);
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[7:2]];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: m_beats = beats already taken in the current burst (0 = none),
    // m_starve = consecutive denied DMA cycles (saturating).
    int            m_beats  = 0;
    int            m_starve = 0;
    logic          m_rvalid = 1'b0;
    logic [31:0]   m_rdata  = '0;
    logic          chk_en   = 1'b0;

    always @(negedge clk) begin
        logic        e_cpu, e_dma, e_we;
        logic [31:0] e_addr;
        if (chk_en) begin
            e_cpu = 1'b0;
            e_dma = 1'b0;
            if (!reset) begin
                if (m_beats > 0) begin
                    if (dma_req) e_dma = 1'b1;
                    else if (cpu_req) e_cpu = 1'b1;
                end else if (dma_req && m_starve >= STARVE_LIMIT) e_dma = 1'b1;
                else if (cpu_req) e_cpu = 1'b1;
                else if (dma_req) e_dma = 1'b1;
            end
            e_we   = e_dma ? dma_we : (e_cpu ? cpu_we : 1'b0);
            e_addr = e_dma ? dma_addr : cpu_addr;

            chk("m_dma_gnt", 32'(dma_gnt), 32'(e_dma));
            chk("m_cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_cpu && !reset));
            chk("m_mem_we", 32'(mem_we), 32'(e_we));
            chk("m_mem_addr", mem_addr, e_addr);
            if (e_cpu || e_dma) chk("m_mem_wdata", mem_wdata, e_dma ? dma_wdata : cpu_wdata);
            chk("m_cpu_rdata", cpu_rdata, mem[e_addr[7:2]]);
            chk("m_dma_rvalid", 32'(dma_rvalid), 32'(m_rvalid));
            chk("m_dma_rdata", dma_rdata, m_rdata);

            if (reset) begin
                m_beats  = 0;
                m_starve = 0;
                m_rvalid = 1'b0;
                m_rdata  = '0;
            end else begin
                if (e_dma) begin
                    m_beats = (dma_last || m_beats + 1 >= MAX_BURST) ? 0 : m_beats + 1;
                    if (!dma_we) m_rdata = mem[dma_addr[7:2]];
                end else begin
                    m_beats = 0;
                end
                if (dma_req && !e_dma)
                    m_starve = (m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
                else
                    m_starve = 0;
                m_rvalid = e_dma && !dma_we;
            end
        end
    end

    // Apply one cycle of inputs just after the rising edge; returns mid-cycle.
    task automatic drive(input logic rst,
                         input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cwd,
                         input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                         input logic dl);
        @(posedge clk);
        #1;
        reset     = rst;
        if (!rst) mem_init = 1'b0;
        cpu_req   = cr;  cpu_we = cw;  cpu_addr = ca;  cpu_wdata = cwd;
        dma_req   = dr;  dma_we = dw;  dma_addr = da;  dma_wdata = dwd;  dma_last = dl;
        #2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic       b_cpu  [0:6];
        int         b_beat [0:6];
        logic       b_gnt  [0:6];
        logic       b_stl  [0:6];

        reset = 1'b1; mem_init = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_last = 0;
        @(posedge clk);
        #1 chk_en = 1'b1;

        // Reset forces everything off even with both ports requesting.
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, 84, 7, 1, 1, 32'h40, 5, 0);
            chk("rst_dma_gnt", 32'(dma_gnt), 0);
            chk("rst_cpu_stall", 32'(cpu_stall), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
        end
        idle();
        chk("rst_rvalid", 32'(dma_rvalid), 0);
        chk("rst_rdata", dma_rdata, 0);

        // CPU store alone.
        drive(0, 1, 1, 84, 7, 0, 0, 0, 0, 0);
        chk("st_we", 32'(mem_we), 1);
        chk("st_addr", mem_addr, 84);
        chk("st_wdata", mem_wdata, 7);
        chk("st_stall", 32'(cpu_stall), 0);
        chk("st_gnt", 32'(dma_gnt), 0);

        // CPU load vs DMA read: CPU first, DMA next, rvalid after.
        drive(0, 1, 0, 16, 0, 1, 0, 32, 0, 1);
        chk("ld_stall", 32'(cpu_stall), 0);
        chk("ld_gnt", 32'(dma_gnt), 0);
        chk("ld_addr", mem_addr, 16);
        chk("ld_rdata", cpu_rdata, 32'h1004);
        drive(0, 0, 0, 0, 0, 1, 0, 32, 0, 1);
        chk("rd_gnt", 32'(dma_gnt), 1);
        chk("rd_addr", mem_addr, 32);
        idle();
        chk("rd_rvalid", 32'(dma_rvalid), 1);
        chk("rd_rdata", dma_rdata, 32'h1008);
        chk("st_mem84", mem[21], 7);

        // Six-beat DMA write burst, CPU arrives at beat 2.
        b_cpu  = '{0, 1, 1, 1, 1, 0, 0};
        b_beat = '{1, 2, 3, 4, 5, 5, 6};
        b_gnt  = '{1, 1, 1, 1, 0, 1, 1};
        b_stl  = '{0, 1, 1, 1, 0, 0, 0};
        for (int c = 0; c < 7; c++) begin
            drive(0, b_cpu[c], 0, 0, 0,
                  1, 1, 32'h80 + 32'(4 * (b_beat[c] - 1)), 32'hB0 + 32'(b_beat[c]), 0);
            chk($sformatf("bu_gnt%0d", c), 32'(dma_gnt), 32'(b_gnt[c]));
            chk($sformatf("bu_stall%0d", c), 32'(cpu_stall), 32'(b_stl[c]));
        end
        // DMA drops mid-burst while CPU asks: CPU served at once.
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("drop_stall", 32'(cpu_stall), 0);
        chk("drop_addr", mem_addr, 0);
        // Back in IDLE with no stale beat count: CPU beats a fresh DMA request.
        drive(0, 1, 0, 4, 0, 1, 0, 32'h60, 0, 1);
        chk("post_gnt", 32'(dma_gnt), 0);
        chk("post_stall", 32'(cpu_stall), 0);
        idle();
        chk("bu_mem1", mem[32], 32'hB1);
        chk("bu_mem6", mem[37], 32'hB6);

        // Starvation: both held high; DMA forced in at cycles 8 and 17.
        for (int k = 0; k < 18; k++) begin
            drive(0, 1, 0, 8, 0, 1, 0, 32'h20, 0, 1);
            chk($sformatf("sv_gnt%0d", k), 32'(dma_gnt), 32'(k == 8 || k == 17));
            chk($sformatf("sv_stall%0d", k), 32'(cpu_stall), 32'(k == 8 || k == 17));
            if (k == 9) begin
                chk("sv_rvalid", 32'(dma_rvalid), 1);
                chk("sv_rdata", dma_rdata, 32'h1008);
            end
        end
        idle();

        // Reset during beat 2 of a DMA write burst.
        drive(0, 0, 0, 0, 0, 1, 1, 32'h3C, 32'hBEEF, 0);
        chk("rb_beat1", 32'(dma_gnt), 1);
        drive(1, 0, 0, 0, 0, 1, 1, 32'h40, 32'hDEAD, 0);
        chk("rb_we", 32'(mem_we), 0);
        chk("rb_gnt", 32'(dma_gnt), 0);
        drive(0, 1, 0, 32'h40, 0, 1, 1, 32'h40, 32'hDEAD, 0);
        chk("rb_stall", 32'(cpu_stall), 0);
        chk("rb_dgnt", 32'(dma_gnt), 0);
        chk("rb_rvalid", 32'(dma_rvalid), 0);
        chk("rb_cpu_rdata", cpu_rdata, 32'h1010);
        idle();
        chk("rb_mem15", mem[15], 32'hBEEF);
        chk("rb_mem16", mem[16], 32'h1010);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
